// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and constants for the stream demultiplexer
package stream_demux_pkg;

    localparam int CNT_W       = 16;
    localparam int BEAT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
    } beat_t;

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - per-output synchronous FIFO with held head value when empty
module demux_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flags, pointer/occupancy update, and head selection (last popped value shown while empty)
    always_comb begin
        full_o  = (occ_q == OCC_W'(DEPTH));
        empty_o = (occ_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
        occ_d   = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - 1'b1;
        end
        hold_d  = do_pop ? mem_q[rptr_q] : hold_q;
        rdata_o = empty_o ? hold_q : mem_q[rptr_q];
    end

    // Control state; reset flushes by clearing occupancy and pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            hold_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            hold_q <= hold_d;
        end
    end

    // Storage needs no reset: entries are only visible once written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-locked 1-to-NUM_OUT stream demux; STREAM_DEMUX_STATS_EN adds packet counters
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int NUM_OUT = 4,
    parameter  int DEPTH   = 2,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_W-1:0]         in_data_i,
    input  logic                      in_last_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [NUM_OUT-1:0]        out_valid_o,
    input  logic [NUM_OUT-1:0]        out_ready_i,
    output logic [NUM_OUT*DATA_W-1:0] out_data_o,
    output logic [NUM_OUT-1:0]        out_last_o,
    output logic                      err_o,
    input  logic                      err_clr_i,
    output logic [NUM_OUT*CNT_W-1:0]  pkt_cnt_o
);

    localparam int BEAT_W = DATA_W + 1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   route_q, route_d;
    logic               err_q, err_d;
    logic [NUM_OUT-1:0] full_w;
    logic [NUM_OUT-1:0] empty_w;
    logic [NUM_OUT-1:0] push_w;
    logic [NUM_OUT-1:0] pop_w;
    logic [BEAT_W-1:0]  rdata_w [NUM_OUT];
    logic               sel_ok;
    logic               fwd_beat;
    logic               hs;
    logic [SEL_W-1:0]   target;
    logic               target_full;

    // Target selection, ready, and push steering
    always_comb begin
        sel_ok      = (int'(sel_i) < NUM_OUT);
        target      = (state_q == FWD) ? route_q : sel_i;
        target_full = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (target == SEL_W'(k)) begin
                target_full = full_w[k];
            end
        end
        case (state_q)
            IDLE:    in_ready_o = sel_ok ? !target_full : 1'b1;
            FWD:     in_ready_o = !target_full;
            DROP:    in_ready_o = 1'b1;
            default: in_ready_o = 1'b0;
        endcase
        if (rst_i) begin
            in_ready_o = 1'b0;
        end
        hs       = in_valid_i && in_ready_o;
        fwd_beat = (state_q == FWD) || ((state_q == IDLE) && sel_ok);
        for (int k = 0; k < NUM_OUT; k++) begin
            push_w[k] = hs && fwd_beat && (target == SEL_W'(k));
        end
    end

    // Packet FSM: lock the route on the first beat, release on the last
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        err_d   = err_q;
        if (hs) begin
            case (state_q)
                IDLE: begin
                    if (sel_ok) begin
                        if (!in_last_i) begin
                            route_d = sel_i;
                            state_d = FWD;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (!in_last_i) begin
                            state_d = DROP;
                        end
                    end
                end
                FWD, DROP: begin
                    if (in_last_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // FSM and error flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        demux_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (BEAT_W)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push_w[k]),
            .pop_i   (pop_w[k]),
            .wdata_i ({in_data_i, in_last_i}),
            .rdata_o (rdata_w[k]),
            .full_o  (full_w[k]),
            .empty_o (empty_w[k])
        );

        assign out_valid_o[k]                  = !empty_w[k];
        assign pop_w[k]                        = !empty_w[k] && out_ready_i[k];
        assign out_data_o[k*DATA_W +: DATA_W]  = rdata_w[k][BEAT_W-1:1];
        assign out_last_o[k]                   = rdata_w[k][0];

`ifdef STREAM_DEMUX_STATS_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Count packets leaving this output, saturating at all-ones
        always_comb begin
            cnt_d = cnt_q;
            if (pop_w[k] && rdata_w[k][0] && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter register
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign pkt_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
`else
        assign pkt_cnt_o[k*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed vector bench for stream_demux
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_vin, a_rdy, a_last, a_err, a_clr;
    logic [15:0] a_din;
    logic [1:0]  a_sel;
    logic [3:0]  a_ov, a_ordy, a_olast;
    logic [63:0] a_dout, a_pkt;

    logic        b_vin, b_rdy, b_last, b_err, b_clr;
    logic [15:0] b_din;
    logic [1:0]  b_sel;
    logic [2:0]  b_ov, b_ordy, b_olast;
    logic [47:0] b_dout, b_pkt;

    stream_demux #(.DATA_W(16), .NUM_OUT(4), .DEPTH(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_vin), .in_ready_o(a_rdy),
        .in_data_i(a_din), .in_last_i(a_last), .sel_i(a_sel),
        .out_valid_o(a_ov), .out_ready_i(a_ordy), .out_data_o(a_dout),
        .out_last_o(a_olast), .err_o(a_err), .err_clr_i(a_clr), .pkt_cnt_o(a_pkt)
    );

    stream_demux #(.DATA_W(16), .NUM_OUT(3), .DEPTH(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_vin), .in_ready_o(b_rdy),
        .in_data_i(b_din), .in_last_i(b_last), .sel_i(b_sel),
        .out_valid_o(b_ov), .out_ready_i(b_ordy), .out_data_o(b_dout),
        .out_last_o(b_olast), .err_o(b_err), .err_clr_i(b_clr), .pkt_cnt_o(b_pkt)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic [1:0]  sel;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        int          ch;
        logic [15:0] exp_d;
        logic        exp_l;
    } vec_t;

    vec_t tbl[14];
    int   nvec  = 0;
    int   nfail = 0;

`ifdef STREAM_DEMUX_STATS_EN
    localparam logic [15:0] EXP_CNT3 = 16'd5;
`else
    localparam logic [15:0] EXP_CNT3 = 16'd0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [15:0] d, input logic l,
                           input logic [1:0] s, input logic [3:0] ordy);
        a_vin = v; a_din = d; a_last = l; a_sel = s; a_ordy = ordy;
    endtask

    task automatic b_drive(input logic v, input logic [15:0] d, input logic l,
                           input logic [1:0] s, input logic clr);
        b_vin = v; b_din = d; b_last = l; b_sel = s; b_clr = clr;
    endtask

    initial begin
        a_drive(0, 16'h0, 0, 2'd0, 4'b1111); a_clr = 1'b0;
        b_drive(0, 16'h0, 0, 2'd0, 0);       b_ordy = 3'b111;
        rst = 1'b1;

        //           v  data       l  sel ordy      rdy ov       ch data       l
        tbl[0]  = '{1, 16'hAF70, 1, 2, 4'b1111, 1, 4'b0100, 2, 16'hAF70, 1};
        tbl[1]  = '{0, 16'h0000, 0, 0, 4'b1111, 1, 4'b0000, 2, 16'hAF70, 1};
        tbl[2]  = '{1, 16'hCFE0, 0, 1, 4'b1111, 1, 4'b0010, 1, 16'hCFE0, 0};
        tbl[3]  = '{1, 16'h7F60, 0, 3, 4'b1111, 1, 4'b0010, 1, 16'h7F60, 0};
        tbl[4]  = '{1, 16'hFF00, 1, 3, 4'b1111, 1, 4'b0010, 1, 16'hFF00, 1};
        tbl[5]  = '{0, 16'h0000, 0, 0, 4'b1111, 1, 4'b0000, 1, 16'hFF00, 1};
        tbl[6]  = '{1, 16'h1111, 0, 0, 4'b1110, 1, 4'b0001, 0, 16'h1111, 0};
        tbl[7]  = '{1, 16'h2222, 0, 0, 4'b1110, 1, 4'b0001, 0, 16'h1111, 0};
        tbl[8]  = '{1, 16'h3333, 1, 0, 4'b1110, 0, 4'b0001, 0, 16'h1111, 0};
        tbl[9]  = '{1, 16'h3333, 1, 0, 4'b1110, 0, 4'b0001, 0, 16'h1111, 0};
        tbl[10] = '{1, 16'h3333, 1, 0, 4'b1111, 0, 4'b0001, 0, 16'h2222, 0};
        tbl[11] = '{1, 16'h3333, 1, 0, 4'b1111, 1, 4'b0001, 0, 16'h3333, 1};
        tbl[12] = '{1, 16'h4444, 1, 1, 4'b1111, 1, 4'b0010, 1, 16'h4444, 1};
        tbl[13] = '{0, 16'h0000, 0, 0, 4'b1111, 1, 4'b0000, 0, 16'h3333, 1};

        // Reset state
        tick(); tick();
        chk("rst_in_ready", a_rdy, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_data", a_dout, 0);
        chk("rst_out_last", a_olast, 0);
        chk("rst_err", a_err, 0);
        chk("rst_pkt_cnt", a_pkt, 0);
        rst = 1'b0;
        #1;

        // Table: single beat, route lock, backpressure
        for (int i = 0; i < 14; i++) begin
            a_drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].sel, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), a_rdy, tbl[i].exp_rdy);
            tick();
            chk($sformatf("vec%0d_out_valid", i), a_ov, tbl[i].exp_ov);
            chk($sformatf("vec%0d_data", i), a_dout[tbl[i].ch*16 +: 16], tbl[i].exp_d);
            chk($sformatf("vec%0d_last", i), a_olast[tbl[i].ch], tbl[i].exp_l);
        end
        chk("main_err_clear", a_err, 0);

        // Invalid select on the 3-output instance
        b_drive(1, 16'hDEAD, 0, 2'd3, 0); #1;
        chk("bad_beat1_ready", b_rdy, 1);
        tick();
        chk("bad_beat1_err", b_err, 1);
        chk("bad_beat1_ov", b_ov, 0);
        b_drive(1, 16'hBEEF, 1, 2'd0, 0); #1;
        chk("bad_beat2_ready", b_rdy, 1);
        tick();
        chk("bad_beat2_ov", b_ov, 0);
        chk("bad_beat2_err", b_err, 1);
        b_drive(0, 16'h0, 0, 2'd0, 1);
        tick();
        chk("err_clr", b_err, 0);
        b_drive(1, 16'hABCD, 1, 2'd3, 1); #1;
        chk("clr_vs_set_ready", b_rdy, 1);
        tick();
        chk("clr_vs_set_err", b_err, 0);
        b_drive(0, 16'h0, 0, 2'd0, 0);
        tick();
        chk("clr_vs_set_after", b_err, 0);
        b_drive(1, 16'h1234, 1, 2'd0, 0);
        tick();
        chk("after_drop_ov", b_ov, 3'b001);
        chk("after_drop_data", b_dout[15:0], 16'h1234);
        b_drive(0, 16'h0, 0, 2'd0, 0);

        // Reset mid-packet
        a_drive(1, 16'h5555, 0, 2'd2, 4'b0000);
        tick();
        chk("midpkt_ov", a_ov, 4'b0100);
        a_drive(0, 16'h0, 0, 2'd2, 4'b0000);
        rst = 1'b1;
        tick();
        chk("midpkt_rst_ov", a_ov, 0);
        chk("midpkt_rst_ready", a_rdy, 0);
        rst = 1'b0;
        a_drive(1, 16'h6666, 1, 2'd0, 4'b1111); #1;
        chk("post_rst_ready", a_rdy, 1);
        tick();
        chk("post_rst_ov", a_ov, 4'b0001);
        chk("post_rst_data", a_dout[15:0], 16'h6666);
        a_drive(0, 16'h0, 0, 2'd0, 4'b1111);

        // Statistics: five single-beat packets to channel 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_drive(1, 16'(16'hA000 + i), 1, 2'd3, 4'b1111); #1;
            chk($sformatf("stats_ready%0d", i), a_rdy, 1);
            tick();
        end
        a_drive(0, 16'h0, 0, 2'd0, 4'b1111);
        tick(); tick(); tick();
        chk("stats_ov_drained", a_ov, 0);
        chk("stats_cnt3", a_pkt[63:48], EXP_CNT3);
        chk("stats_cnt_others", a_pkt[47:0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-NUM_OUT stream demultiplexer with a valid/ready handshake. It is the distribution side of the 16-bit select-mux datapath.
- Steers packets of 16-bit beats from one input stream to the output chosen by sel_i.
- The route is locked for the whole packet, from the first beat through the beat carrying last_i.
- Each output has its own small FIFO, so one stalled consumer does not block packets routed to other outputs.

Parameters:
- DATA_W, 16, beat width in bits.
- NUM_OUT, 4, number of output channels; must be 2 or more.
- DEPTH, 2, entries per output FIFO; must be 2 or more.
- SEL_W, $clog2(NUM_OUT), select width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- in_data_i  in  DATA_W  input beat data.
- in_last_i  in  1  final beat of packet.
- sel_i  in  SEL_W  destination; sampled only on a packet's first beat.
- out_valid_o  out  NUM_OUT  per-output valid.
- out_ready_i  in  NUM_OUT  per-output ready.
- out_data_o  out  NUM_OUT*DATA_W  packed; channel k occupies bits [k*DATA_W +: DATA_W].
- out_last_o  out  NUM_OUT  per-output last.
- err_o  out  1  sticky flag: a packet arrived with sel_i >= NUM_OUT.
- err_clr_i  in  1  clears err_o.
- pkt_cnt_o  out  NUM_OUT*16  per-output completed-packet counters; see Optional Feature.

Behaviour:
- Reset: clk_i and rst_i are a single clock with synchronous, active-high reset.
  - While rst_i = 1: FSM goes to IDLE, all FIFOs flush, err_o = 0, pkt_cnt_o = 0, out_valid_o = 0, out_data_o = 0, out_last_o = 0, in_ready_o = 0.
- FSM states: IDLE, FWD, DROP. A handshake is in_valid_i && in_ready_o.
  - IDLE, handshake, sel_i < NUM_OUT, in_last_i = 0: latch sel_i into route, go to FWD.
  - IDLE, handshake, sel_i < NUM_OUT, in_last_i = 1: single-beat packet; stay in IDLE.
  - IDLE, handshake, sel_i >= NUM_OUT: beat is discarded and err_o is set. Go to DROP if in_last_i = 0, otherwise stay in IDLE.
  - FWD: every beat goes to the latched route and sel_i is ignored. A handshake with in_last_i = 1 returns to IDLE.
  - DROP: in_ready_o = 1 and beats are discarded. A handshake with in_last_i = 1 returns to IDLE.
- Ready (combinational from registered state plus sel_i):
  - in_ready_o = !full of the target FIFO.
  - The target is sel_i in IDLE and the latched route in FWD.
  - In IDLE with sel_i >= NUM_OUT, in_ready_o = 1.
- Latency: a beat accepted at edge N appears on out_*_o[k] after edge N; one cycle to the registered FIFO head if the FIFO was empty.
- FIFO k:
  - Pushes {data, last}; pops when out_valid_o[k] && out_ready_i[k].
  - out_valid_o[k] = !empty; out_data_o and out_last_o show the head entry.
  - When full, a push is not accepted even if a pop happens in the same cycle. The simultaneous push/pop case is reached only when not full.
  - Occupancy stays within 0..DEPTH. Pointers wrap modulo DEPTH.
- out_data_o[k] holds its last value when out_valid_o[k] = 0.
- Other outputs drain independently during a stall on one output.
- err_o: err_clr_i has priority over a set in the same cycle.
- Reset mid-packet: the partial packet is lost. The first beat after reset is treated as a packet start.
- Protocol: once in_valid_i is asserted it is held stable until the handshake. The block does not need to tolerate violations of this.

Optional Feature:
- STREAM_DEMUX_STATS_EN defined:
  - pkt_cnt_o[k] increments when a beat with last = 1 is popped from FIFO k.
  - The counter saturates at 16'hFFFF.
  - Counters clear on rst_i.
- Not defined: pkt_cnt_o is tied to 0 and no counter flops are built.

Decomposition:
- Package stream_demux_pkg:
  - state_e enum {IDLE, FWD, DROP}.
  - beat_t struct {logic [DATA_W-1:0] data; logic last;}.
  - CNT_W = 16 constant.
- Sub-module demux_fifo: synchronous FIFO parameterised by DEPTH and the beat width.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Instantiated NUM_OUT times via generate.

Test Plan:
- Single beat routing: after reset, a beat with data 16'hAF70, sel_i = 2, last = 1 is accepted → out_valid_o = 4'b0100 and channel 2 data = 16'hAF70 one edge later. out_last_o[2] = 1.
- Route lock: a 3-beat packet 16'hCFE0, 16'h7F60, 16'hFF00 with sel_i = 1, where sel_i changes to 3 after beat 1 → all three beats exit channel 1 in order. Channel 3 stays empty.
- Backpressure: out_ready_i[0] = 0 while sending 3 beats to channel 0 with DEPTH = 2 → in_ready_o drops after 2 accepts.
  - A packet to channel 1 can only start after this packet completes.
  - Setting out_ready_i[0] = 1 then drains all 3 beats in order.
- Invalid select: with NUM_OUT = 3, a 2-beat packet with sel_i = 3 → both beats are accepted and dropped, and err_o = 1.
  - err_clr_i then clears err_o; if it is asserted in the same cycle as a new bad packet, err_o stays 0.
- Reset mid-packet: rst_i pulses after beat 1 of a 4-beat packet → out_valid_o = 0 and FSM is IDLE.
  - The next beat, sent with sel_i = 0, routes to channel 0.
- Statistics: with STREAM_DEMUX_STATS_EN defined, 5 single-beat packets to channel 3 are drained → pkt_cnt_o[3] = 5 and the other counters = 0.
  - Without the macro defined, pkt_cnt_o = 0.
